// File: rtl/obq_sched_pkg.sv
// -----------------------------------------------------------------------------
// sys_defs: shared types and sizes for the OBQ and its scheduler.
//   OBQ_SIZE          number of OBQ entries (power of two)
//   IDX_W / SEQ_W     physical index width / sequence tag width (one extra bit)
//   OBQ_ROW_T         one branch-history row stored per OBQ entry
//   obq_seq_t         sequence tag, wraps mod 2*OBQ_SIZE
//   obq_cnt_t         occupancy / index value, 0..OBQ_SIZE
//   obq_sched_state_e scheduler FSM states
// -----------------------------------------------------------------------------
package sys_defs;

  localparam int OBQ_SIZE = 16;
  localparam int IDX_W    = $clog2(OBQ_SIZE);
  localparam int SEQ_W    = IDX_W + 1;
  localparam int BH_SIZE  = 8;

  typedef logic [BH_SIZE-1:0] OBQ_ROW_T;
  typedef logic [SEQ_W-1:0]   obq_seq_t;
  typedef logic [IDX_W:0]     obq_cnt_t;

  localparam obq_cnt_t OBQ_FULL = obq_cnt_t'(OBQ_SIZE);

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_RECOVER = 1'b1
  } obq_sched_state_e;

  // Physical OBQ index of a sequence tag, given the tag sitting at index 0.
  // The subtraction wraps in SEQ_W bits, so tags stay valid across wrap-around.
  function automatic obq_cnt_t seq_to_idx(input obq_seq_t seq, input obq_seq_t head);
    return obq_cnt_t'(seq - head);
  endfunction

endpackage

// File: rtl/obq_recover_timer.sv
// -----------------------------------------------------------------------------
// obq_recover_timer: post-clear stall counter.
//   clock   posedge clock
//   reset   asynchronous active-low reset
//   load_i  (re)start the count at RECOVER_CYC
//   done_o  high while the count sits at 1, i.e. the last stall cycle
// The count decrements every cycle while non-zero and parks at 0.
// -----------------------------------------------------------------------------
module obq_recover_timer #(
  parameter  int RECOVER_CYC = 2,
  localparam int CNT_W       = $clog2(RECOVER_CYC + 1)
) (
  input  logic clock,
  input  logic reset,
  input  logic load_i,
  output logic done_o
);

  logic [CNT_W-1:0] cnt_q;

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= CNT_W'(RECOVER_CYC);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign done_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/obq_sched.sv
// -----------------------------------------------------------------------------
// obq_sched: turns fetch allocations, in-order retirements and mispredict
// recoveries into OBQ write / clear / shift commands (at most one clear or
// shift per cycle) and mirrors the OBQ occupancy for backpressure.
//   clock, reset            posedge clock, asynchronous active-low reset
//   fe_valid/fe_bh_row      fetch allocation request and its history row
//   fe_ready/fe_tag         accept handshake and sequence tag of the accept
//   rt_valid                oldest outstanding branch retired
//   mp_valid/mp_seq         mispredict, squash from mp_seq onward
//   mp_err                  one-cycle pulse: mispredict tag outside occupancy
//   obq_write_en/_clear_en/_shift_en, obq_index, obq_shift_index, obq_bh_row
//                           OBQ commands (combinational, same cycle)
//   occupancy               mirrored OBQ tail
//   recovering              FSM is in RECOVER (fetch stalled)
// Tags are stable across shifts; head_q is the tag living at OBQ index 0.
// -----------------------------------------------------------------------------
module obq_sched
  import sys_defs::*;
#(
  parameter int RECOVER_CYC = 2
) (
  input  logic     clock,
  input  logic     reset,
  input  logic     fe_valid,
  input  OBQ_ROW_T fe_bh_row,
  output logic     fe_ready,
  output obq_seq_t fe_tag,
  input  logic     rt_valid,
  input  logic     mp_valid,
  input  obq_seq_t mp_seq,
  output logic     mp_err,
  output logic     obq_write_en,
  output logic     obq_clear_en,
  output logic     obq_shift_en,
  output obq_cnt_t obq_index,
  output obq_cnt_t obq_shift_index,
  output OBQ_ROW_T obq_bh_row,
  output obq_cnt_t occupancy,
  output logic     recovering
);

  obq_sched_state_e state_q;
  obq_seq_t         head_q,  head_d;
  obq_seq_t         alloc_q, alloc_d;
  obq_cnt_t         count_q, count_d;
  obq_cnt_t         pend_q,  pend_d;
  logic             mp_err_q;

  obq_cnt_t mp_idx;
  logic     mp_ok;
  logic     rt_ok;
  logic     rec_done;

  // A mispredict is only meaningful if its tag maps inside the live entries.
  assign mp_idx = seq_to_idx(mp_seq, head_q);
  assign mp_ok  = mp_valid && (mp_idx < count_q);

  // Retiring more branches than are outstanding is illegal; drop it here.
  assign rt_ok  = rt_valid && (pend_q != count_q);

  // Backpressure looks at registered occupancy only; a same-cycle shift does
  // not free a slot until the next cycle. Gated by reset so the port is low
  // while reset is asserted.
  assign fe_ready = reset && (state_q == S_IDLE) && !mp_valid && (count_q < OBQ_FULL);

  assign obq_write_en    = fe_valid && fe_ready;
  assign obq_clear_en    = mp_ok;
  assign obq_index       = mp_ok ? mp_idx : '0;
  // Pending retirements are flushed as one batched shift, but a clear wins.
  assign obq_shift_en    = !mp_ok && (pend_q != '0);
  assign obq_shift_index = obq_shift_en ? (pend_q - obq_cnt_t'(1)) : '0;
  assign obq_bh_row      = fe_bh_row;

  assign fe_tag     = alloc_q;
  assign occupancy  = count_q;
  assign recovering = (state_q == S_RECOVER);
  assign mp_err     = mp_err_q;

  // NOTE: every variable driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    head_d  = head_q;
    alloc_d = alloc_q;
    count_d = count_q;
    pend_d  = pend_q;

    if (mp_ok) begin
      // Keep entries 0..mp_idx-1; the squashed tag is reused for the next alloc.
      count_d = mp_idx;
      alloc_d = mp_seq;
    end else begin
      if (obq_shift_en) begin
        head_d  = head_q + obq_seq_t'(pend_q);
        count_d = count_q - pend_q;
        pend_d  = '0;
      end
      // The OBQ places this row at count_q - pend_q, i.e. right after the shift.
      if (obq_write_en) begin
        alloc_d = alloc_q + obq_seq_t'(1);
        count_d = count_d + obq_cnt_t'(1);
      end
    end

    if (rt_ok) begin
      pend_d = pend_d + obq_cnt_t'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q   <= '0;
      alloc_q  <= '0;
      count_q  <= '0;
      pend_q   <= '0;
      mp_err_q <= 1'b0;
    end else begin
      head_q   <= head_d;
      alloc_q  <= alloc_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
      mp_err_q <= mp_valid && !mp_ok;
    end
  end

  // Stall fetch for RECOVER_CYC cycles after each accepted clear; a new clear
  // during recovery restarts the wait.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (mp_ok) state_q <= S_RECOVER;
        end
        S_RECOVER: begin
          if (!mp_ok && rec_done) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  obq_recover_timer #(
    .RECOVER_CYC(RECOVER_CYC)
  ) u_timer (
    .clock (clock),
    .reset (reset),
    .load_i(mp_ok),
    .done_o(rec_done)
  );

  // Retirement must never outrun the outstanding branches.
  a_rt_legal : assert property (@(posedge clock) disable iff (!reset)
                                !(rt_valid && (pend_q == count_q)));

endmodule

// File: tb/tb_obq_sched.sv
// -----------------------------------------------------------------------------
// tb_obq_sched: directed scenarios plus randomized traffic against a queue
// model of the OBQ contents (list of live tags in index order). Mispredict
// validity and clear index come from searching that list; shifts pop from the
// front, writes push at the back.
// -----------------------------------------------------------------------------
module tb_obq_sched;
  import sys_defs::*;

  localparam int RECOVER_CYC = 2;

  logic     clock;
  logic     reset;
  logic     fe_valid;
  OBQ_ROW_T fe_bh_row;
  logic     fe_ready;
  obq_seq_t fe_tag;
  logic     rt_valid;
  logic     mp_valid;
  obq_seq_t mp_seq;
  logic     mp_err;
  logic     obq_write_en;
  logic     obq_clear_en;
  logic     obq_shift_en;
  obq_cnt_t obq_index;
  obq_cnt_t obq_shift_index;
  OBQ_ROW_T obq_bh_row;
  obq_cnt_t occupancy;
  logic     recovering;

  obq_sched #(.RECOVER_CYC(RECOVER_CYC)) dut (
    .clock          (clock),
    .reset          (reset),
    .fe_valid       (fe_valid),
    .fe_bh_row      (fe_bh_row),
    .fe_ready       (fe_ready),
    .fe_tag         (fe_tag),
    .rt_valid       (rt_valid),
    .mp_valid       (mp_valid),
    .mp_seq         (mp_seq),
    .mp_err         (mp_err),
    .obq_write_en   (obq_write_en),
    .obq_clear_en   (obq_clear_en),
    .obq_shift_en   (obq_shift_en),
    .obq_index      (obq_index),
    .obq_shift_index(obq_shift_index),
    .obq_bh_row     (obq_bh_row),
    .occupancy      (occupancy),
    .recovering     (recovering)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Model state
  obq_seq_t mq[$];
  int       m_pend;
  obq_seq_t m_alloc;
  int       m_rec;
  bit       m_err;

  // Decisions of the current cycle, applied by tick()
  bit c_found;
  int c_pos;
  bit c_write;
  bit c_shift;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int find(input obq_seq_t s);
    foreach (mq[i]) if (mq[i] == s) return i;
    return -1;
  endfunction

  task automatic m_reset();
    mq.delete();
    m_pend  = 0;
    m_alloc = '0;
    m_rec   = 0;
    m_err   = 1'b0;
  endtask

  // Drive one cycle of inputs and compare every output against the model.
  task automatic apply(input bit fe, input bit rt, input bit mp, input obq_seq_t seq);
    int pos;
    bit e_ready;
    fe_valid  = fe;
    rt_valid  = rt;
    mp_valid  = mp;
    mp_seq    = seq;
    fe_bh_row = OBQ_ROW_T'($urandom);
    #2;
    pos     = find(seq);
    c_found = mp && (pos >= 0);
    c_pos   = pos;
    e_ready = (m_rec == 0) && !mp && (mq.size() < OBQ_SIZE);
    c_write = fe && e_ready;
    c_shift = !c_found && (m_pend > 0);
    check("fe_ready",    fe_ready,        e_ready);
    check("fe_tag",      fe_tag,          m_alloc);
    check("write_en",    obq_write_en,    c_write);
    check("clear_en",    obq_clear_en,    c_found);
    check("index",       obq_index,       c_found ? pos : 0);
    check("shift_en",    obq_shift_en,    c_shift);
    check("shift_index", obq_shift_index, c_shift ? m_pend - 1 : 0);
    check("bh_row",      obq_bh_row,      fe_bh_row);
    check("occupancy",   occupancy,       mq.size());
    check("recovering",  recovering,      m_rec > 0);
    check("mp_err",      mp_err,          m_err);
  endtask

  task automatic tick();
    @(posedge clock);
    if (c_found) begin
      while (mq.size() > c_pos) void'(mq.pop_back());
      m_alloc = mp_seq;
      m_rec   = RECOVER_CYC;
    end else begin
      if (c_shift) begin
        repeat (m_pend) void'(mq.pop_front());
        m_pend = 0;
      end
      if (c_write) begin
        mq.push_back(m_alloc);
        m_alloc = m_alloc + obq_seq_t'(1);
      end
      if (m_rec > 0) m_rec--;
    end
    if (rt_valid) m_pend++;
    m_err = mp_valid && !c_found;
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    fe_valid = 1'b0;
    rt_valid = 1'b0;
    mp_valid = 1'b0;
    mp_seq   = '0;
    m_reset();
    repeat (2) @(posedge clock);
    #1;
    check("rst_occ",   occupancy,  0);
    check("rst_ready", fe_ready,   0);
    check("rst_rec",   recovering, 0);
    reset = 1'b1;
    #1;
    check("rst_release_ready", fe_ready, 1);
  endtask

  initial begin
    fe_bh_row = '0;
    do_reset();

    // 1: three allocations, tags 0,1,2
    for (int i = 0; i < 3; i++) begin
      apply(1, 0, 0, '0);
      check("t1_tag", fe_tag, i);
      tick();
    end
    check("t1_occ", occupancy, 3);

    // 2: fill to 16, then one retirement frees a slot a cycle later
    repeat (13) begin apply(1, 0, 0, '0); tick(); end
    apply(1, 1, 0, '0);
    check("t2_full_occ",   occupancy, 16);
    check("t2_full_ready", fe_ready,  0);
    tick();
    apply(1, 0, 0, '0);
    check("t2_shift",     obq_shift_en,    1);
    check("t2_shift_idx", obq_shift_index, 0);
    check("t2_no_write",  obq_write_en,    0);
    tick();
    apply(1, 0, 0, '0);
    check("t2_write", obq_write_en, 1);
    check("t2_tag16", fe_tag,       16);
    tick();
    check("t2_occ16", occupancy, 16);
    // head is now tag 1: it maps to index 0
    apply(0, 0, 1, 5'd1);
    check("t2_head_idx", obq_index, 0);
    tick();

    // 3/4: mispredict with retirements on the mp cycle and the next
    do_reset();
    repeat (5) begin apply(1, 0, 0, '0); tick(); end
    apply(0, 1, 1, 5'd2);
    check("t3_clear",     obq_clear_en, 1);
    check("t3_index",     obq_index,    2);
    check("t3_no_shift",  obq_shift_en, 0);
    tick();
    apply(0, 1, 0, '0);
    check("t3_occ2",      occupancy,       2);
    check("t3_shift",     obq_shift_en,    1);
    check("t3_shift_idx", obq_shift_index, 0);
    check("t3_stall1",    fe_ready,        0);
    tick();
    apply(0, 0, 0, '0);
    check("t4_occ1",      occupancy,       1);
    check("t4_shift_idx", obq_shift_index, 0);
    check("t4_stall2",    fe_ready,        0);
    tick();
    apply(1, 0, 0, '0);
    check("t3_ready_back", fe_ready,  1);
    check("t3_tag2",       fe_tag,    2);
    check("t4_occ0",       occupancy, 0);
    tick();
    apply(0, 0, 1, 5'd2);
    check("t4_head2", obq_index, 0);
    tick();
    apply(0, 0, 0, '0); tick();
    apply(0, 0, 0, '0); tick();

    // 5: out-of-range mispredict
    do_reset();
    repeat (5) begin apply(1, 0, 0, '0); tick(); end
    apply(0, 0, 1, 5'd7);
    check("t5_no_clear", obq_clear_en, 0);
    tick();
    apply(1, 0, 0, '0);
    check("t5_err",   mp_err,       1);
    check("t5_write", obq_write_en, 1);
    check("t5_tag",   fe_tag,       5);
    tick();
    apply(1, 0, 0, '0);
    check("t5_err_pulse", mp_err, 0);
    tick();

    // 6: asynchronous reset in the middle of recovery
    apply(0, 0, 1, 5'd1);
    tick();
    apply(0, 0, 0, '0);
    reset = 1'b0;
    #1;
    check("t6_rec",   recovering,   0);
    check("t6_ready", fe_ready,     0);
    check("t6_occ",   occupancy,    0);
    check("t6_err",   mp_err,       0);
    check("t6_write", obq_write_en, 0);
    check("t6_clear", obq_clear_en, 0);
    check("t6_shift", obq_shift_en, 0);
    m_reset();
    @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    check("t6_occ_after", occupancy, 0);
    check("t6_tag_after", fe_tag,    0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      bit       fe, rt, mp;
      obq_seq_t s;
      int       p;
      fe = ($urandom_range(0, 9) < 6);
      rt = (m_pend < mq.size()) && ($urandom_range(0, 9) < 4);
      mp = ($urandom_range(0, 19) == 0);
      s  = obq_seq_t'($urandom);
      if (mp && ($urandom_range(0, 1) == 1) && (mq.size() > m_pend + int'(rt)))
        s = mq[$urandom_range(m_pend + int'(rt), mq.size() - 1)];
      p = find(s);
      // A mispredict never squashes branches already retired.
      if (mp && (p >= 0) && (p < m_pend + int'(rt))) mp = 1'b0;
      apply(fe, rt, mp, s);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
